// File: rtl/multi_edge_pulse_gen_pkg.sv
// Shared types and helpers for the multi-channel edge-triggered pulse generator.
package multi_edge_pulse_gen_pkg;

  typedef enum logic [1:0] {
    RISE = 2'b00,
    FALL = 2'b01,
    BOTH = 2'b10,
    OFF  = 2'b11
  } edge_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ch_state_t;

  function automatic logic edge_sel(input edge_mode_t m, input logic rise, input logic fall);
    logic r;
    r = 1'b0;
    case (m)
      RISE:    r = rise;
      FALL:    r = fall;
      BOTH:    r = rise | fall;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/multi_edge_pulse_gen_channel.sv
// One channel: input synchronizer, edge history, IDLE/ACTIVE pulse FSM with
// length counter, and sticky overrun flag.
module pulse_gen_channel
  import multi_edge_pulse_gen_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             d_i,
  input  logic             en_i,
  input  logic [1:0]       mode_i,
  input  logic [LEN_W-1:0] pulse_len_i,
  input  logic             retrig_i,
  input  logic             ovr_clr_i,
  output logic             q_o,
  output logic             busy_o,
  output logic             overrun_o
);

  logic             s;
  logic             last_q;
  logic             rise, fall, edge_det;
  logic             ovr_d, ovr_q;
  logic             q_q;
  logic [LEN_W-1:0] cnt_q;
  ch_state_t        state_q;

  // A programmed length of 0 behaves like 1, so the reload value saturates at 0.
  function automatic logic [LEN_W-1:0] len_load(input logic [LEN_W-1:0] len);
    return (len == '0) ? '0 : len - 1'b1;
  endfunction

  generate
    if (SYNC_STAGES == 0) begin : g_nosync
      assign s = d_i;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0] sync_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= SYNC_STAGES'({sync_q, d_i});
      end
      assign s = sync_q[SYNC_STAGES-1];
    end
  endgenerate

  // History tracks the synchronized input even while the channel is disabled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= 1'b0;
    else     last_q <= s;
  end

  assign rise     = s & ~last_q;
  assign fall     = ~s & last_q;
  assign edge_det = en_i & edge_sel(edge_mode_t'(mode_i), rise, fall);

  // A fresh overrun outranks a simultaneous clear.
  assign ovr_d = (ovr_q & ~ovr_clr_i) |
                 (edge_det & (state_q == ACTIVE) & ~retrig_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      q_q     <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      ovr_q <= ovr_d;
      case (state_q)
        IDLE: begin
          if (edge_det) begin
            state_q <= ACTIVE;
            cnt_q   <= len_load(pulse_len_i);
            q_q     <= 1'b1;
          end
        end
        ACTIVE: begin
          if (!en_i) begin
            state_q <= IDLE;
            q_q     <= 1'b0;
          end else if (edge_det && retrig_i) begin
            cnt_q <= len_load(pulse_len_i);
          end else if (cnt_q == '0) begin
            state_q <= IDLE;
            q_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          q_q     <= 1'b0;
        end
      endcase
    end
  end

  assign q_o       = q_q;
  assign busy_o    = q_q;
  assign overrun_o = ovr_q;

endmodule

// File: rtl/multi_edge_pulse_gen.sv
// N_CH independent edge-triggered pulse generators sharing length and retrigger controls.
module multi_edge_pulse_gen
  import multi_edge_pulse_gen_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int LEN_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_CH-1:0]   D,
  input  logic [N_CH-1:0]   en,
  input  logic [2*N_CH-1:0] mode,
  input  logic [LEN_W-1:0]  pulse_len,
  input  logic              retrig,
  input  logic [N_CH-1:0]   ovr_clr,
  output logic [N_CH-1:0]   Q,
  output logic [N_CH-1:0]   busy,
  output logic [N_CH-1:0]   overrun
);

  generate
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
      pulse_gen_channel #(
        .SYNC_STAGES(SYNC_STAGES),
        .LEN_W      (LEN_W)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .d_i        (D[i]),
        .en_i       (en[i]),
        .mode_i     (mode[2*i +: 2]),
        .pulse_len_i(pulse_len),
        .retrig_i   (retrig),
        .ovr_clr_i  (ovr_clr[i]),
        .q_o        (Q[i]),
        .busy_o     (busy[i]),
        .overrun_o  (overrun[i])
      );
    end
  endgenerate

endmodule

// File: tb/tb_multi_edge_pulse_gen.sv
// Directed bench: per-cycle vector table on an unsynchronized instance plus
// hand sequences on a two-stage-synchronized instance for latency and reset.
module tb_multi_edge_pulse_gen;

  logic       clk = 1'b0;
  logic       rst0, rst2;
  logic [3:0] d0, d2, en, clr;
  logic [7:0] mode;
  logic [3:0] plen;
  logic       retrig;
  logic [3:0] q0, busy0, ovr0, q2, busy2, ovr2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  multi_edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(0), .LEN_W(4)) dut0 (
    .clk(clk), .rst(rst0), .D(d0), .en(en), .mode(mode), .pulse_len(plen),
    .retrig(retrig), .ovr_clr(clr), .Q(q0), .busy(busy0), .overrun(ovr0)
  );

  multi_edge_pulse_gen #(.N_CH(4), .SYNC_STAGES(2), .LEN_W(4)) dut2 (
    .clk(clk), .rst(rst2), .D(d2), .en(en), .mode(mode), .pulse_len(plen),
    .retrig(retrig), .ovr_clr(clr), .Q(q2), .busy(busy2), .overrun(ovr2)
  );

  typedef struct packed {
    logic [3:0] d;
    logic [3:0] en;
    logic [7:0] mode;
    logic [3:0] plen;
    logic       retrig;
    logic [3:0] clr;
    logic [3:0] eq;
    logic [3:0] eo;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] d, input logic [3:0] e, input logic [7:0] m,
                     input logic [3:0] pl, input logic rt, input logic [3:0] c,
                     input logic [3:0] eq, input logic [3:0] eo);
    vec_t v;
    v.d = d; v.en = e; v.mode = m; v.plen = pl; v.retrig = rt;
    v.clr = c; v.eq = eq; v.eo = eo;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step2(input logic r, input logic dv, input logic e, input string nm);
    @(posedge clk);
    #1;
    rst2 = r;
    d2   = {3'b000, dv};
    @(negedge clk);
    chk({nm, " q"},    32'(q2),    {28'd0, 3'b000, e});
    chk({nm, " busy"}, 32'(busy2), {28'd0, 3'b000, e});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst0 = 1'b1; rst2 = 1'b1;
    d0 = 4'h0; d2 = 4'h0; en = 4'hF; clr = 4'h0;
    mode = 8'h00; plen = 4'd3; retrig = 1'b0;

    // Rows: D, en, mode, pulse_len, retrig, ovr_clr | expected Q/busy, overrun
    // Single rise, length 3
    add(4'h0,4'hF,8'h00,4'd3,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h00,4'd3,0,4'h0,4'h0,4'h0);
    add(4'h1,4'hF,8'h00,4'd3,0,4'h0,4'h0,4'h0);
    add(4'h1,4'hF,8'h00,4'd3,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd3,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd3,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd3,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h00,4'd3,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h00,4'd3,0,4'h0,4'h0,4'h0);
    // Both-edge mode on ch1, length 1
    add(4'h0,4'hF,8'h08,4'd1,0,4'h0,4'h0,4'h0);
    add(4'h2,4'hF,8'h08,4'd1,0,4'h0,4'h0,4'h0);
    add(4'h2,4'hF,8'h08,4'd1,0,4'h0,4'h2,4'h0);
    add(4'h2,4'hF,8'h08,4'd1,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h08,4'd1,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h08,4'd1,0,4'h0,4'h2,4'h0);
    add(4'h0,4'hF,8'h08,4'd1,0,4'h0,4'h0,4'h0);
    // Retrigger, length 4
    add(4'h1,4'hF,8'h00,4'd4,1,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h00,4'd4,1,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd4,1,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd4,1,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd4,1,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd4,1,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd4,1,4'h0,4'h1,4'h0);
    add(4'h0,4'hF,8'h00,4'd4,1,4'h0,4'h0,4'h0);
    // No retrigger: overrun
    add(4'h1,4'hF,8'h00,4'd4,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h00,4'd4,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd4,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd4,0,4'h0,4'h1,4'h1);
    add(4'h1,4'hF,8'h00,4'd4,0,4'h0,4'h1,4'h1);
    add(4'h1,4'hF,8'h00,4'd4,0,4'h0,4'h0,4'h1);
    // Clear, final-cycle edge, clear colliding with set
    add(4'h1,4'hF,8'h00,4'd2,0,4'h1,4'h0,4'h1);
    add(4'h0,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h0);
    add(4'h1,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'h00,4'd2,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd2,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h1);
    add(4'h0,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h1);
    add(4'h1,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h1);
    add(4'h0,4'hF,8'h00,4'd2,0,4'h0,4'h1,4'h1);
    add(4'h1,4'hF,8'h00,4'd2,0,4'h1,4'h1,4'h1);
    add(4'h1,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h1);
    add(4'h0,4'hF,8'h00,4'd2,0,4'h1,4'h0,4'h1);
    add(4'h0,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h0);
    // Length 0, ch2 disabled then enabled, ch3 mode off
    add(4'h4,4'hB,8'hC0,4'd0,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hB,8'hC0,4'd0,0,4'h0,4'h0,4'h0);
    add(4'h4,4'hB,8'hC0,4'd0,0,4'h0,4'h0,4'h0);
    add(4'h4,4'hB,8'hC0,4'd0,0,4'h0,4'h0,4'h0);
    add(4'h0,4'hF,8'hC0,4'd0,0,4'h0,4'h0,4'h0);
    add(4'hC,4'hF,8'hC0,4'd0,0,4'h0,4'h0,4'h0);
    add(4'hC,4'hF,8'hC0,4'd0,0,4'h0,4'h4,4'h0);
    add(4'hC,4'hF,8'hC0,4'd0,0,4'h0,4'h0,4'h0);
    // All channels at once
    add(4'h0,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h0);
    add(4'hF,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h0);
    add(4'hF,4'hF,8'h00,4'd2,0,4'h0,4'hF,4'h0);
    add(4'hF,4'hF,8'h00,4'd2,0,4'h0,4'hF,4'h0);
    add(4'hF,4'hF,8'h00,4'd2,0,4'h0,4'h0,4'h0);
    // Disable mid-pulse
    add(4'h0,4'hF,8'h00,4'd5,0,4'h0,4'h0,4'h0);
    add(4'h1,4'hF,8'h00,4'd5,0,4'h0,4'h0,4'h0);
    add(4'h1,4'hF,8'h00,4'd5,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hE,8'h00,4'd5,0,4'h0,4'h1,4'h0);
    add(4'h1,4'hF,8'h00,4'd5,0,4'h0,4'h0,4'h0);
    add(4'h1,4'hF,8'h00,4'd5,0,4'h0,4'h0,4'h0);

    // Reset state while reset is held
    #2;
    chk("rst0 q", 32'(q0), 32'd0);
    chk("rst0 ovr", 32'(ovr0), 32'd0);
    chk("rst2 q", 32'(q2), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst0 busy", 32'(busy0), 32'd0);
    chk("rst2 busy", 32'(busy2), 32'd0);
    chk("rst2 ovr", 32'(ovr2), 32'd0);
    @(posedge clk);
    #1;
    rst0 = 1'b0; rst2 = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      d0 = vecs[i].d; en = vecs[i].en; mode = vecs[i].mode;
      plen = vecs[i].plen; retrig = vecs[i].retrig; clr = vecs[i].clr;
      @(negedge clk);
      chk($sformatf("row%0d q", i),    32'(q0),    32'(vecs[i].eq));
      chk($sformatf("row%0d busy", i), 32'(busy0), 32'(vecs[i].eq));
      chk($sformatf("row%0d ovr", i),  32'(ovr0),  32'(vecs[i].eo));
    end

    // Two-stage synchronizer latency, then asynchronous abort mid-pulse
    en = 4'hF; mode = 8'h00; plen = 4'd3; retrig = 1'b0; clr = 4'h0;
    step2(0, 0, 0, "s2 idle");
    step2(0, 1, 0, "s2 t");
    step2(0, 1, 0, "s2 t+1");
    step2(0, 1, 0, "s2 t+2");
    step2(0, 1, 1, "s2 t+3");
    @(posedge clk);
    #1;
    rst2 = 1'b1;
    d2   = 4'h0;
    #1;
    chk("s2 async q", 32'(q2), 32'd0);
    chk("s2 async busy", 32'(busy2), 32'd0);
    for (int k = 0; k < 6; k++) step2(0, 0, 0, $sformatf("s2 post-abort %0d", k));

    // Input held high across reset release must yield a fresh rise pulse
    step2(0, 1, 0, "s2b 0");
    step2(0, 1, 0, "s2b 1");
    step2(0, 1, 0, "s2b 2");
    step2(0, 1, 1, "s2b 3");
    step2(0, 1, 1, "s2b 4");
    step2(0, 1, 1, "s2b 5");
    step2(0, 1, 0, "s2b 6");
    step2(1, 1, 0, "s2b rst");
    step2(0, 1, 0, "s2b r");
    step2(0, 1, 0, "s2b r+1");
    step2(0, 1, 0, "s2b r+2");
    step2(0, 1, 1, "s2b r+3");
    step2(0, 1, 1, "s2b r+4");
    step2(0, 1, 1, "s2b r+5");
    step2(0, 1, 0, "s2b r+6");
    step2(0, 1, 0, "s2b r+7");
    chk("s2 ovr", 32'(ovr2), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
